// File: rtl/enc8to3_pkg.sv
// Shared constants, state encoding and helpers for the queued 8-to-3 priority encoder.
package enc8to3_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] popcount8(input logic [N_REQ-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_REQ; i++)
            n = n + CNT_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational priority pick over an 8-bit candidate set; direction set by LSB_FIRST.
module prio_pick8
    import enc8to3_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic [N_REQ-1:0] cand,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        any = |cand;
        idx = '0;
        // Scan from lowest to highest priority so the last hit is the winner.
        if (LSB_FIRST) begin
            for (int i = N_REQ - 1; i >= 0; i--)
                if (cand[i]) idx = i[IDX_W-1:0];
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (cand[i]) idx = i[IDX_W-1:0];
        end
        onehot = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/enc8to3_queue.sv
// Sequential 8-to-3 priority encoder: captures request pulses into a pending set and
// presents them one index at a time under a valid/ready handshake.
module enc8to3_queue
    import enc8to3_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic             valid,
    output logic [IDX_W-1:0] idx,
    input  logic             ready,
    output logic [CNT_W-1:0] pend_cnt
);

    state_t           state;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] pick_onehot;
    logic [N_REQ-1:0] pending_after_pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             load;

    assign cand               = pending | req;
    assign load               = (state == IDLE) || ready;
    assign pending_after_pick = cand & ~pick_onehot;

    prio_pick8 #(.LSB_FIRST(LSB_FIRST)) u_pick (
        .cand   (cand),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= 1'b0;
            idx      <= '0;
            pending  <= '0;
            pend_cnt <= '0;
        end else if (load) begin
            if (pick_any) begin
                state    <= HOLD;
                valid    <= 1'b1;
                idx      <= pick_idx;
                pending  <= pending_after_pick;
                pend_cnt <= popcount8(pending_after_pick);
            end else begin
                // idx deliberately keeps its last value when going idle.
                state    <= IDLE;
                valid    <= 1'b0;
                pending  <= '0;
                pend_cnt <= '0;
            end
        end else begin
            // Stalled: a new request on the held index re-queues it as a separate entry.
            pending  <= cand;
            pend_cnt <= popcount8(cand);
        end
    end

endmodule

// File: tb/tb_enc8to3_queue.sv
// Scoreboard bench: stimulus pushes expected accepts, a monitor pops on each valid&&ready.
module tb_enc8to3_queue;
    import enc8to3_pkg::*;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_REQ-1:0] req0, req1;
    logic             ready0, ready1;
    logic             valid0, valid1;
    logic [IDX_W-1:0] idx0, idx1;
    logic [CNT_W-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;

    enc8to3_queue #(.LSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .valid(valid0),
        .idx(idx0), .ready(ready0), .pend_cnt(cnt0)
    );

    enc8to3_queue #(.LSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .valid(valid1),
        .idx(idx1), .ready(ready1), .pend_cnt(cnt1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input int i, input int c);
        exp_t e;
        e.idx = IDX_W'(i);
        e.cnt = CNT_W'(c);
        q0.push_back(e);
    endtask

    task automatic push1(input int i, input int c);
        exp_t e;
        e.idx = IDX_W'(i);
        e.cnt = CNT_W'(c);
        q1.push_back(e);
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid&&ready here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid0 && ready0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb0_unexpected got idx %0d expected no accept", idx0);
                end else begin
                    e0 = q0.pop_front();
                    chk("sb0_idx", int'(idx0), int'(e0.idx));
                    chk("sb0_cnt", int'(cnt0), int'(e0.cnt));
                end
            end
            if (valid1 && ready1) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb1_unexpected got idx %0d expected no accept", idx1);
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_idx", int'(idx1), int'(e1.idx));
                    chk("sb1_cnt", int'(cnt1), int'(e1.cnt));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        req0   = '0;
        req1   = '0;
        ready0 = 1'b0;
        ready1 = 1'b1;
        #2;
        chk("rst_valid", int'(valid0), 0);
        chk("rst_idx",   int'(idx0),   0);
        chk("rst_cnt",   int'(cnt0),   0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-HOLD: idx 3 held with pending 8'h41.
        req0 = 8'h08;
        tick();
        req0 = 8'h41;
        tick();
        req0 = 8'h00;
        chk("hold_valid", int'(valid0), 1);
        chk("hold_idx",   int'(idx0),   3);
        chk("hold_cnt",   int'(cnt0),   2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_valid", int'(valid0), 0);
        chk("async_idx",   int'(idx0),   0);
        chk("async_cnt",   int'(cnt0),   0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", int'(valid0), 0);

        // Single pulse.
        req0 = 8'h20;
        ready0 = 1'b1;
        push0(5, 0);
        tick();
        req0 = 8'h00;
        chk("pulse_valid", int'(valid0), 1);
        tick();
        chk("pulse_drop", int'(valid0), 0);

        // Burst on both priority orders.
        req0 = 8'hA2;
        req1 = 8'hA2;
        push0(7, 2); push0(5, 1); push0(1, 0);
        push1(1, 2); push1(5, 1); push1(7, 0);
        tick();
        req0 = 8'h00;
        req1 = 8'h00;
        tick();
        tick();
        tick();
        chk("burst0_idle", int'(valid0), 0);
        chk("burst1_idle", int'(valid1), 0);

        // Backpressure: idx 3 held while req[6] and req[3] pulse.
        ready0 = 1'b0;
        req0 = 8'h08;
        push0(3, 2); push0(6, 1); push0(3, 0);
        tick();
        req0 = 8'h40;
        tick();
        req0 = 8'h08;
        tick();
        req0 = 8'h00;
        chk("bp_idx_a", int'(idx0), 3);
        chk("bp_cnt_a", int'(cnt0), 2);
        tick();
        chk("bp_idx_b", int'(idx0), 3);
        chk("bp_cnt_b", int'(cnt0), 2);
        chk("bp_valid", int'(valid0), 1);
        ready0 = 1'b1;
        tick();
        tick();
        tick();
        chk("bp_idle", int'(valid0), 0);

        // Accept and new higher-priority request in the same cycle.
        ready0 = 1'b0;
        req0 = 8'h05;
        tick();
        req0 = 8'h00;
        chk("same_idx", int'(idx0), 2);
        chk("same_cnt", int'(cnt0), 1);
        ready0 = 1'b1;
        req0 = 8'h10;
        push0(2, 1); push0(4, 1); push0(0, 0);
        tick();
        req0 = 8'h00;
        tick();
        tick();
        chk("same_idle", int'(valid0), 0);

        tick();
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
